// File: rtl/sbtx_framer_pkg.sv
// Shared sideband definitions: FSM states, frame geometry, CRC-16 defaults.
package sbtx_framer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_GAP,
      S_CRC_LO,
      S_CRC_HI
   } state_t;

   localparam int          FRAME_LEN    = 10;
   localparam logic [3:0]  LAST_BIT     = 4'(FRAME_LEN - 1);
   localparam logic [15:0] DEF_CRC_INIT = 16'hFFFF;
   localparam logic [15:0] DEF_CRC_POLY = 16'h8005;

   // Bit idx of a 10-bit frame: start 0, data LSB first, stop 1.
   function automatic logic frame_bit(
      input logic [7:0] b,
      input logic [3:0] idx
   );
      logic r;
      r = 1'b1;
      if (idx == 4'd0)
         r = 1'b0;
      else if (idx <= 4'd8)
         r = b[3'(idx - 4'd1)];
      return r;
   endfunction

endpackage

// File: rtl/sbtx_framer_if.sv
// Byte-level valid/ready handshake into the sideband framer.
interface sbtx_framer_if;

   logic       trans_valid;
   logic [7:0] trans_data;
   logic       trans_last;
   logic       trans_ready;

   modport master (
      output trans_valid,
      output trans_data,
      output trans_last,
      input  trans_ready
   );

   modport slave (
      input  trans_valid,
      input  trans_data,
      input  trans_last,
      output trans_ready
   );

endinterface

// File: rtl/sbtx_framer_crc16.sv
// Bit-serial CRC-16 LFSR, MSB-first register form, no final XOR.
module sb_crc16
   import sbtx_framer_pkg::*;
#(
   parameter logic [15:0] INIT = DEF_CRC_INIT,
   parameter logic [15:0] POLY = DEF_CRC_POLY
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        enable,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic fb;

   assign fb = crc[15] ^ bit_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         crc <= INIT;
      else if (clear)
         crc <= INIT;
      else if (enable)
         crc <= {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
   end

endmodule

// File: rtl/sbtx_framer.sv
// Sideband transmit framer: serialises payload bytes as 10-bit
// frames, then appends a CRC-16 as two frames on the parity line.
module sbtx_framer
   import sbtx_framer_pkg::*;
#(
   parameter logic [15:0] CRC_INIT = DEF_CRC_INIT,
   parameter logic [15:0] CRC_POLY = DEF_CRC_POLY
) (
   input  logic         sb_clk,
   input  logic         rst,
   sbtx_framer_if.slave trans,
   output logic         trans_ser,
   output logic         parity,
   output logic         sbtx_sel,
   output logic         busy
);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  data_q, data_d;
   logic        last_q, last_d;
   logic        rdy, hs, at_end;
   logic        crc_clr, crc_en, crc_bit;
   logic [15:0] crc;

   assign at_end = (cnt_q == LAST_BIT);

   always_ff @(posedge sb_clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         data_q  <= 8'h00;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      last_d  = last_q;
      rdy     = 1'b0;
      crc_clr = 1'b0;
      unique case (state_q)
         S_IDLE: rdy = 1'b1;
         S_DATA: begin
            cnt_d = cnt_q + 4'd1;
            if (at_end) begin
               cnt_d = 4'd0;
               if (last_q) begin
                  state_d = S_CRC_LO;
               end else begin
                  rdy     = 1'b1;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: rdy = 1'b1;
         S_CRC_LO: begin
            cnt_d = cnt_q + 4'd1;
            if (at_end) begin
               cnt_d   = 4'd0;
               state_d = S_CRC_HI;
            end
         end
         S_CRC_HI: begin
            cnt_d = cnt_q + 4'd1;
            if (at_end) begin
               cnt_d   = 4'd0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Held low while reset is asserted so no byte is taken.
      rdy = rdy & ~rst;
      hs  = trans.trans_valid & rdy;
      if (hs) begin
         state_d = S_DATA;
         cnt_d   = 4'd0;
         data_d  = trans.trans_data;
         last_d  = trans.trans_last;
         crc_clr = (state_q == S_IDLE);
      end
   end

   assign trans.trans_ready = rdy;

   assign crc_en  = (state_q == S_DATA)
                  && (cnt_q != 4'd0) && !at_end;
   assign crc_bit = frame_bit(data_q, cnt_q);

   sb_crc16 #(
      .INIT (CRC_INIT),
      .POLY (CRC_POLY)
   ) u_crc (
      .clk    (sb_clk),
      .rst    (rst),
      .clear  (crc_clr),
      .enable (crc_en),
      .bit_in (crc_bit),
      .crc    (crc)
   );

   always_comb begin
      trans_ser = 1'b1;
      parity    = 1'b1;
      sbtx_sel  = 1'b0;
      busy      = (state_q != S_IDLE);
      unique case (state_q)
         S_DATA:   trans_ser = frame_bit(data_q, cnt_q);
         S_CRC_LO: begin
            sbtx_sel = 1'b1;
            parity   = frame_bit(crc[7:0], cnt_q);
         end
         S_CRC_HI: begin
            sbtx_sel = 1'b1;
            parity   = frame_bit(crc[15:8], cnt_q);
         end
         default: ;
      endcase
   end

endmodule

// File: doc/sbtx_framer.md
SBTX_FRAMER -- requirements
Module: sbtx_framer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter: CRC_INIT, default 16'hFFFF, CRC-16 register seed loaded at each transaction start.
REQ-003 Parameter: CRC_POLY, default 16'h8005, i.e. x^16+x^15+x^2+1, normal (MSB-first register) form.
REQ-004 sb_clk  input  1  sideband bit clock; one line bit per cycle.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 trans_valid  input  1  trans_data/trans_last are valid.
REQ-007 trans_data  input  8  transaction payload byte.
REQ-008 trans_last  input  1  current byte is the final payload byte.
REQ-009 trans_ready  output  1  byte accepted when trans_valid and trans_ready are both 1.
REQ-010 trans_ser  output  1  framed payload serial bit to downstream mux input 0.
REQ-011 parity  output  1  framed CRC serial bit to downstream mux input 1.
REQ-012 sbtx_sel  output  1  0 selects trans_ser, 1 selects parity.
REQ-013 busy  output  1  transaction in progress (state not IDLE).

Function
REQ-014 Each byte SHALL be sent as a 10-bit frame: start bit 0, data bits LSB first, stop bit 1; one bit per sb_clk cycle; 4-bit bit counter 0..9.
REQ-015 States SHALL be IDLE, DATA, GAP, CRC_LO, CRC_HI.
REQ-016 IDLE: trans_ready=1, trans_ser=1, parity=1, sbtx_sel=0; on handshake, capture byte/last, load CRC with CRC_INIT, go DATA with bit counter 0.
REQ-017 DATA: trans_ser drives the current frame bit; the register for the first frame bit updates on the cycle after the handshake (latency 1).
REQ-018 Each data bit SHALL be shifted into the CRC LFSR in the cycle it is driven; start and stop bits SHALL NOT update the CRC.
REQ-019 At bit 9 of a non-last frame, trans_ready=1; a handshake in that cycle starts the next frame back-to-back (no idle bit); no handshake moves to GAP.
REQ-020 GAP: trans_ser=1, trans_ready=1; a handshake returns to DATA at bit 0; a gap length is unbounded.
REQ-021 At bit 9 of the last frame, trans_ready=0 and the next state is CRC_LO with sbtx_sel=1 from the first CRC_LO cycle.
REQ-022 CRC_LO then CRC_HI SHALL each send a 10-bit frame on parity carrying CRC[7:0] then CRC[15:8], LSB first, with no final XOR.
REQ-023 trans_ready SHALL be 0 in CRC_LO and CRC_HI; trans_valid is ignored there.
REQ-024 After bit 9 of CRC_HI, the state returns to IDLE and sbtx_sel returns to 0 on the same edge.
REQ-025 Total line bits for an N-byte transaction with no gaps SHALL be 10*N+20.
REQ-026 trans_ser SHALL be 1 whenever sbtx_sel=1.
REQ-027 parity SHALL be 1 whenever sbtx_sel=0.
REQ-028 trans_valid dropping mid-frame SHALL have no effect; captured data is held in an internal register.

Reset
REQ-029 On rst=1 outputs SHALL be: trans_ser=1, parity=1, sbtx_sel=0, trans_ready=0, busy=0; state IDLE, counter 0, CRC=CRC_INIT.
REQ-030 trans_ready SHALL rise in the first cycle after rst deasserts.
REQ-031 Reset asserted mid-frame or mid-CRC SHALL abort the transaction immediately; no partial CRC is sent afterwards.

Structure
REQ-032 A shared sideband package SHALL hold the state enum, frame length 10, CRC_INIT and CRC_POLY constants.
REQ-033 One sub-module, sb_crc16, SHALL hold the bit-serial LFSR with ports clear, enable and bit_in, and a 16-bit output.

Verification
REQ-034 Single byte 8'hA5 with last=1 -> trans_ser shows 0,1,0,1,0,0,1,0,1,1; then 20 parity bits whose CRC bytes match the golden model over 8'hA5.
REQ-035 Three bytes 01,02,03 back-to-back -> 30 contiguous trans_ser bits with no idle, then 20 CRC bits; busy high for exactly 50 cycles.
REQ-036 Two bytes with trans_valid low for 5 cycles between them -> 5 idle 1 bits in GAP; the CRC equals the no-gap case.
REQ-037 rst pulse at DATA bit 4 -> outputs reach reset values asynchronously; the next transaction sends a correct CRC from CRC_INIT.
REQ-038 trans_valid held high during CRC_LO/HI -> no handshake occurs; the pending byte is accepted on the first IDLE cycle.
